// File: rtl/sram_march_bist.sv
// March C- built-in self-test for a single-port synchronous SRAM (registered read data).
// Issues one SRAM operation per cycle and compares each read one cycle later.
module sram_march_bist #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_act,
  output logic [ERR_W-1:0]  err_count,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic [3:0] {IDLE, M0, M1, M2, M3, M4, M5, FLUSH, DONE} state_t;

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic              bg;
  } rd_req_t;

  localparam logic [ADDR_W-1:0] AMAX  = '1;
  localparam logic [ADDR_W-1:0] A_ONE = 1;
  localparam logic [ERR_W-1:0]  E_ONE = 1;

  state_t            state;
  logic              phase;
  rd_req_t           rd_q;
  logic              start_acc, issue_rd, rd_bg, miss;
  logic [DATA_W-1:0] exp_word;

  assign start_acc = start && (state == IDLE || state == DONE);
  assign issue_rd  = !sram_we && (state inside {M1, M2, M3, M4, M5});
  assign rd_bg     = (state == M2) || (state == M4);
  assign exp_word  = {DATA_W{rd_q.bg}};
  assign miss      = rd_q.vld && (sram_rdata != exp_word);

  // Output registers always hold the operation issued in the current cycle;
  // in two-op elements phase=0 is the read, phase=1 the write to the same address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= M0;
            busy       <= 1'b1;
            done       <= 1'b0;
            phase      <= 1'b0;
            sram_we    <= 1'b1;
            sram_addr  <= '0;
            sram_wdata <= '0;
          end
        end
        M0: begin
          if (sram_addr == AMAX) begin
            state     <= M1;
            sram_we   <= 1'b0;
            sram_addr <= '0;
          end else begin
            sram_addr <= sram_addr + A_ONE;
          end
        end
        M1, M2: begin
          if (!phase) begin
            phase      <= 1'b1;
            sram_we    <= 1'b1;
            sram_wdata <= {DATA_W{state == M1}};
          end else begin
            phase      <= 1'b0;
            sram_we    <= 1'b0;
            sram_wdata <= '0;
            if (sram_addr == AMAX) begin
              state     <= (state == M1) ? M2 : M3;
              sram_addr <= (state == M1) ? '0 : AMAX;
            end else begin
              sram_addr <= sram_addr + A_ONE;
            end
          end
        end
        M3, M4: begin
          if (!phase) begin
            phase      <= 1'b1;
            sram_we    <= 1'b1;
            sram_wdata <= {DATA_W{state == M3}};
          end else begin
            phase      <= 1'b0;
            sram_we    <= 1'b0;
            sram_wdata <= '0;
            if (sram_addr == '0) begin
              state     <= (state == M3) ? M4 : M5;
              sram_addr <= (state == M3) ? AMAX : '0;
            end else begin
              sram_addr <= sram_addr - A_ONE;
            end
          end
        end
        M5: begin
          if (sram_addr == AMAX) begin
            state     <= FLUSH;
            sram_addr <= '0;
          end else begin
            sram_addr <= sram_addr + A_ONE;
          end
        end
        FLUSH: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One-deep compare stage: the SRAM returns read data the cycle after issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q      <= '0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_act  <= '0;
      err_count <= '0;
    end else begin
      rd_q.vld  <= issue_rd;
      rd_q.addr <= sram_addr;
      rd_q.bg   <= rd_bg;
      if (start_acc) begin
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_exp  <= '0;
        fail_act  <= '0;
        err_count <= '0;
      end else if (miss) begin
        fail <= 1'b1;
        if (err_count != '1) err_count <= err_count + E_ONE;
        if (!fail) begin
          fail_addr <= rd_q.addr;
          fail_exp  <= exp_word;
          fail_act  <= sram_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: behavioural SRAM with stuck-at injection, operation-trace
// scoreboard and directed end-of-test checks.
module tb_sram_march_bist;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [15:0] wdata;
  } op_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, fail, sram_we;
  logic [3:0]  fail_addr, sram_addr;
  logic [15:0] fail_exp, fail_act, sram_wdata;
  logic [15:0] sram_rdata = '0;
  logic [7:0]  err_count;

  logic        start4 = 1'b0;
  logic        busy4, done4, fail4, sram_we4;
  logic [3:0]  fail_addr4, sram_addr4, err_count4;
  logic [15:0] fail_exp4, fail_act4, sram_wdata4;
  logic [15:0] sram_rdata4 = '0;

  logic [15:0] mem [16];
  logic [15:0] s1  [16];
  op_t         exp_q [$];
  int          n_chk = 0;
  int          n_err = 0;
  int          busy_cnt = 0;

  always #5 clk = ~clk;

  sram_march_bist dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_act(fail_act), .err_count(err_count),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  sram_march_bist #(.ADDR_W(4), .DATA_W(16), .ERR_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4), .fail(fail4),
    .fail_addr(fail_addr4), .fail_exp(fail_exp4), .fail_act(fail_act4), .err_count(err_count4),
    .sram_we(sram_we4), .sram_addr(sram_addr4), .sram_wdata(sram_wdata4), .sram_rdata(sram_rdata4)
  );

  // Registered-read SRAM; s1 forces bits to 1 on the read path.
  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_wdata;
    else         sram_rdata <= mem[sram_addr] | s1[sram_addr];
  end

  // Second SRAM: every cell reads back as zero.
  always @(posedge clk) if (!sram_we4) sram_rdata4 <= '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_op(input logic we, input int a, input logic [15:0] d);
    op_t o;
    o.we = we; o.addr = a[3:0]; o.wdata = d;
    exp_q.push_back(o);
  endtask

  task automatic build_trace();
    for (int a = 0; a < 16; a++) push_op(1'b1, a, 16'h0000);
    for (int a = 0; a < 16; a++) begin push_op(1'b0, a, 16'h0); push_op(1'b1, a, 16'hFFFF); end
    for (int a = 0; a < 16; a++) begin push_op(1'b0, a, 16'h0); push_op(1'b1, a, 16'h0000); end
    for (int a = 15; a >= 0; a--) begin push_op(1'b0, a, 16'h0); push_op(1'b1, a, 16'hFFFF); end
    for (int a = 15; a >= 0; a--) begin push_op(1'b0, a, 16'h0); push_op(1'b1, a, 16'h0000); end
    for (int a = 0; a < 16; a++) push_op(1'b0, a, 16'h0);
  endtask

  // Pop one expected operation per busy cycle; the FLUSH cycle finds the queue empty.
  always @(negedge clk) begin
    op_t o;
    if (busy === 1'b1) begin
      busy_cnt++;
      if (exp_q.size() > 0) begin
        o = exp_q.pop_front();
        chk("op_we", sram_we, o.we);
        chk("op_addr", sram_addr, o.addr);
        if (o.we) chk("op_wdata", sram_wdata, o.wdata);
      end
    end
  end

  task automatic pulse_start();
    build_trace();
    busy_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run(input int restart_at);
    int n;
    pulse_start();
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_fail", fail, 0);
    chk("start_errcnt", err_count, 0);
    chk("start_faddr", fail_addr, 0);
    chk("start_fexp", fail_exp, 0);
    chk("start_fact", fail_act, 0);
    n = 1;
    while (done !== 1'b1 && n < 400) begin
      start = (n == restart_at);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    chk("busy_end", busy, 0);
    chk("busy_cycles", busy_cnt, 161);
    chk("trace_left", exp_q.size(), 0);
    chk("idle_we", sram_we, 0);
    chk("idle_addr", sram_addr, 0);
  endtask

  initial begin
    int n;
    foreach (s1[i]) s1[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_we", sram_we, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_wdata", sram_wdata, 0);
    chk("rst_errcnt", err_count, 0);
    chk("rst_faddr", fail_addr, 0);
    rst = 1'b0;

    // Fault-free run, memory ends all zeros
    run(-1);
    chk("ok_fail", fail, 0);
    chk("ok_errcnt", err_count, 0);
    for (int a = 0; a < 16; a++) chk("mem_zero", mem[a], 16'h0000);

    // Bit 3 stuck-at-1 at address 5
    s1[5] = 16'h0008;
    run(-1);
    chk("sa1_fail", fail, 1);
    chk("sa1_faddr", fail_addr, 5);
    chk("sa1_fexp", fail_exp, 16'h0000);
    chk("sa1_fact", fail_act, 16'h0008);
    chk("sa1_errcnt", err_count, 3);

    // Clean rerun clears fail state on start
    s1[5] = 16'h0000;
    run(-1);
    chk("rerun_fail", fail, 0);
    chk("rerun_errcnt", err_count, 0);

    // Start pulsed while busy is ignored
    run(40);
    chk("restart_fail", fail, 0);

    // Reset in the middle of M2
    pulse_start();
    n = 0;
    while (busy_cnt < 60 && n < 200) begin @(posedge clk); n++; end
    #1 rst = 1'b1;
    #1;
    exp_q.delete();
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_fail", fail, 0);
    chk("abort_we", sram_we, 0);
    chk("abort_addr", sram_addr, 0);
    chk("abort_wdata", sram_wdata, 0);
    chk("abort_errcnt", err_count, 0);
    chk("abort_fexp", fail_exp, 0);
    chk("abort_fact", fail_act, 0);
    @(posedge clk); #1 rst = 1'b0;
    run(-1);
    chk("post_abort_fail", fail, 0);

    // All cells stuck at zero, 4-bit saturating counter
    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    n = 0;
    while (done4 !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    chk("sa0_done", done4, 1);
    chk("sa0_busy", busy4, 0);
    chk("sa0_fail", fail4, 1);
    chk("sa0_errcnt", err_count4, 15);
    chk("sa0_faddr", fail_addr4, 0);
    chk("sa0_fexp", fail_exp4, 16'hFFFF);
    chk("sa0_fact", fail_act4, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
